// File: rtl/count_monitor_if.sv
// Monitor-side bundle: the counter's observed inputs plus the monitor's check results.
// Handshake: no valid/ready; every rising clk edge samples count/load/data/up_down/clr.
interface count_monitor_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       count;
    logic             load;
    logic [3:0]       data;
    logic             up_down;
    logic             clr;

    logic             wrap_pulse;
    logic [CNT_W-1:0] wrap_cnt;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic             err_sticky;
    logic             armed;
    logic [0:0]       state;

    modport master (
        output count, load, data, up_down, clr,
        input  wrap_pulse, wrap_cnt, err_pulse, err_cnt, err_sticky, armed, state
    );

    modport slave (
        input  count, load, data, up_down, clr,
        output wrap_pulse, wrap_cnt, err_pulse, err_cnt, err_sticky, armed, state
    );
endinterface

// File: rtl/count_monitor.sv
// Checks a 4-bit up/down counter one step behind: predicts the next count from the
// controls seen at each edge and compares it with the sample at the following edge.
module count_monitor #(
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    count_monitor_if.slave mon
);

    localparam logic [0:0]       ST_INIT  = 1'b0;
    localparam logic [0:0]       ST_ARMED = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [0:0]       state_q;
    logic [3:0]       exp_q;
    logic             wrap_pend_q;
    logic             wrap_pulse_q;
    logic             err_pulse_q;
    logic [CNT_W-1:0] wrap_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic             err_sticky_q;

    logic [3:0]       exp_next;
    logic             wrap_next;
    logic             checking;
    logic             mismatch;
    logic             wrap_hit;

    // Prediction for the step the counter takes at this edge (modulo-16 arithmetic).
    always_comb begin
        exp_next  = 4'd0;
        wrap_next = 1'b0;
        if (mon.load) begin
            exp_next = mon.data;
        end else if (mon.up_down) begin
            exp_next  = mon.count + 4'd1;
            wrap_next = (mon.count == 4'd15);
        end else begin
            exp_next  = mon.count - 4'd1;
            wrap_next = (mon.count == 4'd0);
        end
    end

    // A wrap is credited only when the wrapped step was actually observed.
    always_comb begin
        checking = (state_q == ST_ARMED);
        mismatch = checking && (mon.count != exp_q);
        wrap_hit = checking && (mon.count == exp_q) && wrap_pend_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            exp_q       <= 4'd0;
            wrap_pend_q <= 1'b0;
        end else if (mon.clr) begin
            state_q     <= ST_INIT;
            exp_q       <= 4'd0;
            wrap_pend_q <= 1'b0;
        end else begin
            state_q     <= ST_ARMED;
            exp_q       <= exp_next;
            wrap_pend_q <= wrap_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
        end else if (mon.clr) begin
            wrap_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
        end else begin
            wrap_pulse_q <= wrap_hit;
            err_pulse_q  <= mismatch;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else if (mon.clr) begin
            wrap_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (wrap_hit && (wrap_cnt_q != CNT_MAX)) begin
                wrap_cnt_q <= wrap_cnt_q + 1'b1;
            end
            if (mismatch && (err_cnt_q != CNT_MAX)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_sticky_q <= 1'b0;
        end else if (mon.clr) begin
            err_sticky_q <= 1'b0;
        end else if (mismatch) begin
            err_sticky_q <= 1'b1;
        end
    end

    assign mon.wrap_pulse = wrap_pulse_q;
    assign mon.wrap_cnt   = wrap_cnt_q;
    assign mon.err_pulse  = err_pulse_q;
    assign mon.err_cnt    = err_cnt_q;
    assign mon.err_sticky = err_sticky_q;
    assign mon.armed      = (state_q == ST_ARMED);
    assign mon.state      = state_q;

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the wrap and error event counters; legal range 4..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert handled by the source.
REQ-004 count  input  4  current value of the upstream up/down counter, sampled every rising clk edge.
REQ-005 load  input  1  load control driven to the counter in the same cycle (1 = counter takes data at this edge).
REQ-006 data  input  4  load value driven to the counter in the same cycle.
REQ-007 up_down  input  1  direction driven to the counter in the same cycle (1 = increment, 0 = decrement).
REQ-008 clr  input  1  synchronous clear of monitor state and counters.
REQ-009 wrap_pulse  output  1  one-cycle strobe: a checked counter step crossed 15->0 (up) or 0->15 (down).
REQ-010 wrap_cnt  output  CNT_W  saturating count of wrap events.
REQ-011 err_pulse  output  1  one-cycle strobe: observed count differs from the predicted count.
REQ-012 err_cnt  output  CNT_W  saturating count of error events.
REQ-013 err_sticky  output  1  set on first error, held until clr or reset.
REQ-014 armed  output  1  1 when a prediction is held and the next sample will be checked.

Function
REQ-015 The module SHALL implement a two-state FSM: INIT (no prediction held) and ARMED (prediction held); armed = (state == ARMED).
REQ-016 On every rising edge with clr=0, the module SHALL register exp_q = load ? data : (up_down ? count+1 : count-1), all arithmetic modulo 16.
REQ-017 At the same edge, it SHALL register wrap_pend_q = !load && ((up_down && count==15) || (!up_down && count==0)).
REQ-018 At the same edge, INIT SHALL go to ARMED; ARMED SHALL stay ARMED.
REQ-019 At an edge in ARMED, if count != exp_q, err_pulse SHALL be 1 for the following cycle, err_cnt SHALL increment, and err_sticky SHALL set.
REQ-020 At an edge in ARMED, if count == exp_q and wrap_pend_q == 1, wrap_pulse SHALL be 1 for the following cycle and wrap_cnt SHALL increment.
REQ-021 Check latency: the step decided at edge k SHALL be checked at edge k+1, with the pulse visible during cycle k+1..k+2. No combinational path from inputs to outputs.
REQ-022 In INIT no comparison SHALL be made; err_pulse and wrap_pulse SHALL be 0 for the cycle after any edge taken in INIT.
REQ-023 wrap_cnt and err_cnt SHALL saturate at 2^CNT_W-1; further events still pulse but do not change the count.
REQ-024 A mismatch with wrap_pend_q=1 SHALL count only as an error, not as a wrap.
REQ-025 clr=1 at an edge SHALL return the FSM to INIT, zero both counters, err_sticky, and pulses, and discard the prediction; clr overrides a simultaneous error or wrap.
REQ-026 A load of a value equal to the current count SHALL be checked like any other load, with no wrap credited.

Reset
REQ-027 While rst=0, the module SHALL hold state=INIT, armed=0, wrap_pulse=0, err_pulse=0, wrap_cnt=0, err_cnt=0, err_sticky=0, exp_q=0, wrap_pend_q=0, regardless of clk.
REQ-028 Reset asserted mid-operation SHALL discard any pending check; the first edge after release SHALL be an INIT edge, with no check.

Verification
REQ-029 Reset release, up_down=1, load=0, count stepping 0,1,2,... -> armed=1 after first edge; err_cnt stays 0; first wrap_pulse appears one cycle after count=0 follows 15, and wrap_cnt=1.
REQ-030 Load data=9 while count=4, then count=9 -> no error and no wrap. Repeat with count=10 injected instead -> err_pulse once, err_cnt=1, err_sticky=1.
REQ-031 Down-count through 0: count 1,0,15 with up_down=0 -> exactly one wrap_pulse, after the 15 sample. Load data=0 at count=0 -> no wrap.
REQ-032 Saturation with CNT_W=4: force 20 mismatches -> err_cnt=15, err_pulse still toggles for each mismatch.
REQ-033 clr asserted in the same cycle as a mismatch -> err_pulse=0, err_cnt=0, armed=0 next cycle; next edge re-arms with no check.
REQ-034 rst pulled low asynchronously between edges while ARMED -> all outputs 0 immediately; after release, a deliberately wrong count at the first edge produces no error.
